// File: rtl/axi_wr_bridge_pkg.sv
// axi_wr_bridge_pkg: shared encodings for the AXI write bridge
package axi_wr_bridge_pkg;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  localparam logic [2:0] WT_BYTE = 3'b000;
  localparam logic [2:0] WT_HALF = 3'b001;
  localparam logic [2:0] WT_WORD = 3'b010;
  localparam logic [2:0] WT_LINE = 3'b100;
  localparam logic [2:0] SIZE_WORD = 3'd2;
  function automatic logic [2:0] beat_size(input logic [2:0] t);
    return (t == WT_BYTE || t == WT_HALF || t == WT_WORD) ? t : SIZE_WORD;
  endfunction
endpackage

// File: rtl/axi_wr_beat_buf.sv
// axi_wr_beat_buf: captured write line plus beat counter selecting the current word
module axi_wr_beat_buf #(
  parameter int LINE_WORDS = 8,
  localparam int LINE_BITS = 32 * LINE_WORDS,
  localparam int CW = $clog2(LINE_WORDS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] data,
  input  logic                 adv,
  input  logic                 clr,
  output logic [CW-1:0]        cnt,
  output logic [31:0]          word
);
  logic [LINE_BITS-1:0] buffer;
  assign word = buffer[{cnt, 5'b0} +: 32];
  always_ff @(posedge clk) if (load) buffer <= data;
  always_ff @(posedge clk) cnt <= rst || clr ? '0 : adv ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/axi_wr_bridge.sv
// axi_wr_bridge: single-outstanding write bridge from cache write port to AXI
module axi_wr_bridge
  import axi_wr_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  localparam int LINE_BITS = 32 * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic [2:0]           wr_type,
  input  logic [31:0]          wr_addr,
  input  logic [3:0]           wr_wstrb,
  input  logic [LINE_BITS-1:0] wr_data,
  output logic                 wr_rdy,
  output logic                 wr_done,
  input  logic [31:0]          rd_addr_chk,
  output logic                 rd_hazard,
  output logic [31:0]          awaddr,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic                 bvalid,
  output logic                 bready
);
  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam logic [31:0] LINE_MASK = 32'(4 * LINE_WORDS - 1);
  wr_state_t state, nxt;
  logic [31:0] addr_q;
  logic [2:0] type_q;
  logic [3:0] strb_q;
  logic [CW-1:0] cnt;
  logic [31:0] word;
  logic line, accept, beat;
  assign line = type_q == WT_LINE;
  assign wr_rdy = state == W_IDLE && !rst;
  assign accept = wr_req && wr_rdy;
  assign awaddr = line ? addr_q & ~LINE_MASK : addr_q;
  assign awlen = line ? 8'(LINE_WORDS - 1) : 8'd0;
  assign awsize = beat_size(type_q);
  assign awvalid = state == W_ADDR;
  assign wvalid = state == W_DATA;
  assign wdata = word;
  assign wstrb = line ? 4'hf : strb_q;
  assign wlast = wvalid && 8'(cnt) == awlen;
  assign bready = state == W_RESP;
  assign wr_done = bready && bvalid;
  assign beat = wvalid && wready;
  assign rd_hazard = !rst && state != W_IDLE && (rd_addr_chk & ~LINE_MASK) == (addr_q & ~LINE_MASK);
  axi_wr_beat_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .data (wr_data),
    .adv  (beat),
    .clr  (beat && wlast),
    .cnt  (cnt),
    .word (word)
  );
  always_ff @(posedge clk) state <= rst ? W_IDLE : nxt;
  always_ff @(posedge clk) if (accept) {addr_q, type_q, strb_q} <= {wr_addr, wr_type, wr_wstrb};
  always_comb begin
    nxt = state;
    nxt = (state == W_IDLE && accept) ? W_ADDR :
          (state == W_ADDR && awready) ? W_DATA :
          (state == W_DATA && beat && wlast) ? W_RESP :
          (state == W_RESP && bvalid) ? W_IDLE : state;
  end
endmodule

// File: tb/tb_axi_wr_bridge.sv
// tb_axi_wr_bridge: randomized transaction-level check of the AXI write bridge
module tb_axi_wr_bridge;
  localparam int LW = 8;
  localparam int LB = 32 * LW;
  localparam logic [31:0] M = 32'(4 * LW - 1);
  logic clk = 0, rst = 1, wr_req = 0;
  logic [2:0] wr_type = 0;
  logic [31:0] wr_addr = 0, rd_addr_chk = 0;
  logic [3:0] wr_wstrb = 0;
  logic [LB-1:0] wr_data = 0;
  logic wr_rdy, wr_done, rd_hazard, awvalid, wlast, wvalid, bready;
  logic awready = 0, wready = 0, bvalid = 0;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [3:0] wstrb;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  axi_wr_bridge #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
    .rd_addr_chk(rd_addr_chk), .rd_hazard(rd_hazard), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] d;
    for (int i = 0; i < LW; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction
  function automatic logic [31:0] pick_rd(input logic [31:0] b);
    int c = $urandom_range(2);
    return c == 0 ? (b & ~M) | ($urandom & M) : c == 1 ? (b & ~M) + 32'(4 * LW) : (b & ~M) - 1;
  endfunction
  task automatic run_txn(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                         input logic [LB-1:0] d, input int ar_hold, input int ar_pct,
                         input int w_pct, input int b_pct);
    logic ln = t == 3'b100;
    logic [31:0] ea = ln ? a & ~M : a;
    int nb = ln ? LW : 1;
    logic [2:0] es = (t == 3'b000 || t == 3'b001 || t == 3'b010) ? t : 3'd2;
    int n = 0, k = 0;
    @(negedge clk);
    rd_addr_chk = $urandom;
    #1;
    chk("idle_rdy", wr_rdy, 1);
    chk("idle_hz", rd_hazard, 0);
    wr_req = 1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    @(negedge clk);
    wr_req = 0; wr_type = 3'($urandom); wr_addr = $urandom; wr_wstrb = 4'($urandom); wr_data = rand_line();
    forever begin
      awready = n >= ar_hold && $urandom_range(99) < ar_pct;
      wr_req = 1'($urandom_range(1));
      rd_addr_chk = pick_rd(ea);
      #1;
      chk("aw_valid", awvalid, 1);
      chk("aw_addr", awaddr, ea);
      chk("aw_len", awlen, 8'(nb - 1));
      chk("aw_size", awsize, es);
      chk("aw_no_w", wvalid, 0);
      chk("aw_rdy", wr_rdy, 0);
      chk("aw_hz", rd_hazard, (rd_addr_chk & ~M) == (ea & ~M));
      if (awready) break;
      @(negedge clk);
      if (++n > 200) begin chk("aw_timeout", 1, 0); wr_req = 0; return; end
    end
    @(negedge clk);
    wr_req = 0; awready = 0; n = 0;
    forever begin
      wready = w_pct < 0 ? n % 2 == 0 : $urandom_range(99) < w_pct;
      rd_addr_chk = pick_rd(ea);
      #1;
      chk("w_valid", wvalid, 1);
      chk("w_data", wdata, d[32*k +: 32]);
      chk("w_strb", wstrb, ln ? 4'hf : s);
      chk("w_last", wlast, k == nb - 1);
      chk("w_no_aw", awvalid, 0);
      chk("w_done", wr_done, 0);
      chk("w_hz", rd_hazard, (rd_addr_chk & ~M) == (ea & ~M));
      if (wready && ++k == nb) break;
      @(negedge clk);
      if (++n > 400) begin chk("w_timeout", 1, 0); wready = 0; return; end
    end
    @(negedge clk);
    wready = 0; n = 0;
    forever begin
      bvalid = $urandom_range(99) < b_pct;
      rd_addr_chk = pick_rd(ea);
      #1;
      chk("b_ready", bready, 1);
      chk("b_done", wr_done, bvalid);
      chk("b_no_w", wvalid, 0);
      chk("b_hz", rd_hazard, (rd_addr_chk & ~M) == (ea & ~M));
      if (bvalid) break;
      @(negedge clk);
      if (++n > 200) begin chk("b_timeout", 1, 0); return; end
    end
    @(negedge clk);
    bvalid = 0; rd_addr_chk = ea;
    #1;
    chk("post_rdy", wr_rdy, 1);
    chk("post_hz", rd_hazard, 0);
    chk("post_done", wr_done, 0);
  endtask
  initial begin
    logic [LB-1:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_rdy", wr_rdy, 0);
    chk("rst_hz", rd_hazard, 0);
    rst = 0;
    #1;
    chk("rst_rel_rdy", wr_rdy, 1);
    run_txn(3'b010, 32'h1fd0_f000, 4'hf, LB'(32'h1234_5678), 0, 100, 100, 100);
    run_txn(3'b000, 32'h0000_0103, 4'b1000, rand_line(), 0, 100, 100, 100);
    for (int i = 0; i < LW; i++) d[32*i +: 32] = 32'hA0 + i;
    run_txn(3'b100, 32'h0000_2034, 4'h0, d, 0, 100, -1, 100);
    run_txn(3'b010, $urandom, 4'hf, rand_line(), 5, 100, 100, 100);
    run_txn(3'b110, $urandom, 4'b0110, rand_line(), 0, 100, 100, 100);
    d = rand_line();
    @(negedge clk);
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h0000_3000; wr_data = d;
    @(negedge clk);
    wr_req = 0; awready = 1;
    @(negedge clk);
    awready = 0; wready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_beat3", wdata, d[96 +: 32]);
    rst = 1; rd_addr_chk = 32'h0000_3004;
    @(negedge clk);
    wready = 0;
    #1;
    chk("mid_awvalid", awvalid, 0);
    chk("mid_wvalid", wvalid, 0);
    chk("mid_bready", bready, 0);
    chk("mid_wlast", wlast, 0);
    chk("mid_rdy", wr_rdy, 0);
    chk("mid_hz", rd_hazard, 0);
    rst = 0;
    #1;
    chk("mid_idle", wr_rdy, 1);
    run_txn(3'b010, 32'h0000_4008, 4'hf, rand_line(), 0, 100, 100, 100);
    for (int i = 0; i < 40; i++)
      run_txn($urandom_range(2) == 0 ? 3'b100 : 3'($urandom), $urandom, 4'($urandom), rand_line(),
              $urandom_range(3), $urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(100, 20));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
